// File: rtl/vu_vxu_banked8_lane_wxbar.sv
// Write-side crossbar for the 8-bank lane register file: one registered stage
// steering writeback results to bank write ports, fixed priority on collision.
module vu_vxu_banked8_lane_wxbar #(
    parameter int NBANKS  = 8,
    parameter int NWPORTS = 4,
    parameter int DATA_W  = 65,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NWPORTS-1:0]          wen,
    input  logic [NWPORTS*NBANKS-1:0]   wsel,
    input  logic [NWPORTS*ADDR_W-1:0]   waddr,
    input  logic [NWPORTS*DATA_W-1:0]   wdata,
    input  logic                        cnt_clr,
    output logic [NBANKS-1:0]           bwen,
    output logic [NBANKS*ADDR_W-1:0]    bwaddr,
    output logic [NBANKS*DATA_W-1:0]    bwdata,
    output logic                        conflict,
    output logic [CNT_W-1:0]            conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NBANKS-1:0]         bwen_nxt;
    logic [NBANKS*ADDR_W-1:0]  bwaddr_nxt;
    logic [NBANKS*DATA_W-1:0]  bwdata_nxt;
    logic                      conflict_nxt;

    // Scan sources in priority order; the first requester claims the bank and
    // any later requester to an already-claimed bank marks a conflict.
    always_comb begin
        bwen_nxt     = '0;
        bwaddr_nxt   = bwaddr;
        bwdata_nxt   = bwdata;
        conflict_nxt = 1'b0;
        for (int b = 0; b < NBANKS; b++) begin
            for (int s = 0; s < NWPORTS; s++) begin
                if (wen[s] && wsel[s*NBANKS + b]) begin
                    if (bwen_nxt[b]) begin
                        conflict_nxt = 1'b1;
                    end else begin
                        bwen_nxt[b]                    = 1'b1;
                        bwaddr_nxt[b*ADDR_W +: ADDR_W] = waddr[s*ADDR_W +: ADDR_W];
                        bwdata_nxt[b*DATA_W +: DATA_W] = wdata[s*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bwen     <= '0;
            bwaddr   <= '0;
            bwdata   <= '0;
            conflict <= 1'b0;
        end else begin
            bwen     <= bwen_nxt;
            bwaddr   <= bwaddr_nxt;
            bwdata   <= bwdata_nxt;
            conflict <= conflict_nxt;
        end
    end

    // Clear beats a same-cycle increment; count saturates rather than wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (cnt_clr) begin
            conflict_cnt <= '0;
        end else if (conflict_nxt && conflict_cnt != CNT_MAX) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_vu_vxu_banked8_lane_wxbar.sv
// Directed bench for the lane write crossbar: routing, multicast, priority,
// conflict counting with saturation and clear, and async reset mid-stream.
module tb_vu_vxu_banked8_lane_wxbar;

    localparam int NBANKS  = 8;
    localparam int NWPORTS = 4;
    localparam int DATA_W  = 65;
    localparam int ADDR_W  = 8;
    localparam int CNT_W   = 8;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NWPORTS-1:0]          wen;
    logic [NWPORTS*NBANKS-1:0]   wsel;
    logic [NWPORTS*ADDR_W-1:0]   waddr;
    logic [NWPORTS*DATA_W-1:0]   wdata;
    logic                        cnt_clr;
    logic [NBANKS-1:0]           bwen;
    logic [NBANKS*ADDR_W-1:0]    bwaddr;
    logic [NBANKS*DATA_W-1:0]    bwdata;
    logic                        conflict;
    logic [CNT_W-1:0]            conflict_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    vu_vxu_banked8_lane_wxbar #(
        .NBANKS(NBANKS), .NWPORTS(NWPORTS), .DATA_W(DATA_W),
        .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .wen(wen), .wsel(wsel), .waddr(waddr),
        .wdata(wdata), .cnt_clr(cnt_clr), .bwen(bwen), .bwaddr(bwaddr),
        .bwdata(bwdata), .conflict(conflict), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] baddr(input int b);
        return bwaddr[b*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [DATA_W-1:0] bdata(input int b);
        return bwdata[b*DATA_W +: DATA_W];
    endfunction

    task automatic clear_in();
        wen = '0; wsel = '0; waddr = '0; wdata = '0; cnt_clr = 1'b0;
    endtask

    task automatic set_src(input int s, input logic [NBANKS-1:0] sel,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wen[s]                     = 1'b1;
        wsel[s*NBANKS +: NBANKS]   = sel;
        waddr[s*ADDR_W +: ADDR_W]  = a;
        wdata[s*DATA_W +: DATA_W]  = d;
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clear_in();
        step();
        step();
        check("rst_bwen", bwen, 8'h00);
        check("rst_addr", bwaddr, '0);
        check("rst_data", bwdata, '0);
        check("rst_conf", conflict, 1'b0);
        check("rst_cnt", conflict_cnt, 8'd0);
        reset = 1'b0;
        step();

        // single write to bank 2
        set_src(0, 8'h04, 8'h12, 65'h1_DEAD);
        step();
        check("t1_bwen", bwen, 8'h04);
        check("t1_addr", baddr(2), 8'h12);
        check("t1_data", bdata(2), 65'h1_DEAD);
        check("t1_conf", conflict, 1'b0);

        // four sources to distinct banks
        clear_in();
        set_src(0, 8'h01, 8'h10, 65'h0_00A0);
        set_src(1, 8'h08, 8'h11, 65'h1_00A1);
        set_src(2, 8'h20, 8'h22, 65'h0_00A2);
        set_src(3, 8'h80, 8'h33, 65'h1_00A3);
        step();
        check("t2_bwen", bwen, 8'hA9);
        check("t2_a0", baddr(0), 8'h10);
        check("t2_d0", bdata(0), 65'h0_00A0);
        check("t2_a3", baddr(3), 8'h11);
        check("t2_d3", bdata(3), 65'h1_00A1);
        check("t2_a5", baddr(5), 8'h22);
        check("t2_d5", bdata(5), 65'h0_00A2);
        check("t2_a7", baddr(7), 8'h33);
        check("t2_d7", bdata(7), 65'h1_00A3);
        check("t2_hold2", bdata(2), 65'h1_DEAD);
        check("t2_conf", conflict, 1'b0);
        check("t2_cnt", conflict_cnt, 8'd0);

        // sources 1 and 3 collide on bank 6: source 1 wins
        clear_in();
        set_src(1, 8'h40, 8'h41, 65'h1_1111);
        set_src(3, 8'h40, 8'h43, 65'h0_3333);
        step();
        check("t3_bwen", bwen, 8'h40);
        check("t3_a6", baddr(6), 8'h41);
        check("t3_d6", bdata(6), 65'h1_1111);
        check("t3_conf", conflict, 1'b1);
        check("t3_cnt", conflict_cnt, 8'd1);
        clear_in();
        step();
        check("t3_conf_pulse", conflict, 1'b0);
        check("t3_bwen_idle", bwen, 8'h00);
        check("t3_cnt_hold", conflict_cnt, 8'd1);
        check("t3_d6_hold", bdata(6), 65'h1_1111);

        // wen with empty select is dropped without conflict
        set_src(0, 8'h00, 8'hEE, 65'h1_EEEE);
        set_src(2, 8'h00, 8'hEF, 65'h1_EEEF);
        step();
        check("drop_bwen", bwen, 8'h00);
        check("drop_conf", conflict, 1'b0);
        check("drop_cnt", conflict_cnt, 8'd1);

        // multicast from source 2
        clear_in();
        set_src(2, 8'hFF, 8'h5A, 65'h0_0F0F);
        step();
        check("t4_bwen", bwen, 8'hFF);
        for (int b = 0; b < NBANKS; b++) begin
            check($sformatf("t4_d%0d", b), bdata(b), 65'h0_0F0F);
        end
        check("t4_a4", baddr(4), 8'h5A);
        check("t4_conf", conflict, 1'b0);
        clear_in();
        step();
        check("t4_idle_bwen", bwen, 8'h00);
        check("t4_hold_d0", bdata(0), 65'h0_0F0F);
        check("t4_hold_a7", baddr(7), 8'h5A);

        // sustained conflict on bank 0 to saturate the counter (starts at 1)
        set_src(0, 8'h01, 8'h01, 65'h0_0001);
        set_src(1, 8'h01, 8'h02, 65'h0_0002);
        for (int i = 0; i < 253; i++) step();
        check("t5_cnt254", conflict_cnt, 8'd254);
        for (int i = 0; i < 47; i++) step();
        check("t5_cnt_sat", conflict_cnt, 8'd255);
        check("t5_conf", conflict, 1'b1);
        check("t5_d0_winner", bdata(0), 65'h0_0001);
        cnt_clr = 1'b1;
        step();
        check("t5_clr_cnt", conflict_cnt, 8'd0);
        check("t5_clr_conf", conflict, 1'b1);
        cnt_clr = 1'b0;
        step();
        check("t5_recount", conflict_cnt, 8'd1);

        // async reset while a write sits in the output stage
        clear_in();
        set_src(0, 8'h02, 8'h77, 65'h0_7777);
        step();
        check("t6_pre_bwen", bwen, 8'h02);
        clear_in();
        reset = 1'b1;
        #1;
        check("t6_rst_bwen", bwen, 8'h00);
        check("t6_rst_d1", bdata(1), '0);
        check("t6_rst_conf", conflict, 1'b0);
        check("t6_rst_cnt", conflict_cnt, 8'd0);
        step();
        reset = 1'b0;
        step();
        check("t6_post_bwen", bwen, 8'h00);
        check("t6_post_d1", bdata(1), '0);
        step();
        check("t6_post2_bwen", bwen, 8'h00);
        check("t6_post2_a1", baddr(1), 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
